// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencing (boot hold, run, stall, redirect flush); optional perf counters under FETCH_CTRL_PERF_CNT_EN
module fetch_ctrl #(
  parameter int XLEN = 32,
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall_req,
  output logic            PCSrc,
  output logic [XLEN-1:0] PCimm_out,
  output logic            pc_write_en,
  output logic            ifid_write_en,
  output logic            ifid_flush,
  output logic            fetch_valid,
  output logic [1:0]      ctrl_state
`ifdef FETCH_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     stall_count,
  output logic [31:0]     flush_count
`endif
);
  localparam int MAXC = RESET_HOLD_CYCLES > FLUSH_CYCLES ? RESET_HOLD_CYCLES : FLUSH_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BOOT_LOAD = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, STALL = 2'b10, FLUSH = 2'b11} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fv_q, fv_d;
  logic redirect;
  assign ctrl_state = state_q;
  assign fetch_valid = fv_q;
  // next state and Mealy outputs; a redirect in RUN/STALL wins over a stall
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    PCSrc = 1'b0;
    PCimm_out = '0;
    pc_write_en = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush = 1'b0;
    redirect = 1'b0;
    case (state_q)
      BOOT, FLUSH: begin
        pc_write_en = state_q == FLUSH;
        ifid_write_en = state_q == FLUSH;
        ifid_flush = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        if (branch_taken) begin
          redirect = 1'b1;
          PCSrc = 1'b1;
          PCimm_out = branch_target;
          ifid_flush = 1'b1;
          cnt_d = FLUSH_LOAD;
          state_d = FLUSH;
        end else if (stall_req) begin
          pc_write_en = 1'b0;
          ifid_write_en = 1'b0;
          state_d = STALL;
        end else state_d = RUN;
      end
    endcase
    fv_d = ifid_flush ? 1'b0 : ifid_write_en ? 1'b1 : fv_q;
  end
  // state, countdown and IF/ID valid registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      cnt_q <= BOOT_LOAD;
      fv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fv_q <= fv_d;
    end
  end
`ifdef FETCH_CTRL_PERF_CNT_EN
  // saturating counts of stalled fetch cycles and accepted redirects
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if ((state_q == RUN || state_q == STALL) && !pc_write_en && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (redirect && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
`else
  logic redirect_unused;
  assign redirect_unused = redirect;
`endif
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage.
- Decides each cycle whether the PC advances, stalls, or redirects to a taken-branch target. Drives the IF/ID pipeline-register write and flush.
- Sits between the EX-stage branch-resolution logic, the hazard unit, and the fetch stage. Its PCSrc/PCimm_out outputs feed the fetch stage's PCSrc/PCimm_in inputs.

Parameters:
- XLEN, 32, width of PC and branch target.
- RESET_HOLD_CYCLES, 2, cycles spent in BOOT after reset deasserts before fetching (≥1).
- FLUSH_CYCLES, 1, cycles spent in FLUSH after an accepted redirect (≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
- branch_taken  input  1  EX reports a taken branch/jump this cycle.
- branch_target  input  XLEN  redirect target; valid when branch_taken=1.
- stall_req  input  1  hazard unit requests a fetch stall (load-use).
- PCSrc  output  1  1 = fetch stage loads PCimm_out at the next edge.
- PCimm_out  output  XLEN  redirect address to the fetch stage.
- pc_write_en  output  1  PC register update enable.
- ifid_write_en  output  1  IF/ID register write enable.
- ifid_flush  output  1  clear IF/ID to a bubble.
- fetch_valid  output  1  registered; IF/ID holds a valid instruction.
- ctrl_state  output  2  current state, for debug: BOOT=00, RUN=01, STALL=10, FLUSH=11.

Behaviour:
- Reset values (while in BOOT): PCSrc=0, PCimm_out=0, pc_write_en=0, ifid_write_en=0, ifid_flush=1, fetch_valid=0, ctrl_state=00. Internal counter loads RESET_HOLD_CYCLES-1.
- reset==0 in any state, at any cycle: next edge forces BOOT and reloads the counter. Reset overrides every other input.
- Outputs are combinational from state and the current inputs (Mealy). State, counter and fetch_valid are registered.
- Default outputs in every non-BOOT state: PCSrc=0, PCimm_out=0.
- BOOT:
  - Enables 0, ifid_flush=1.
  - Counter decrements each cycle; at 0, next state is RUN.
  - branch_taken and stall_req are ignored.
- RUN:
  - Default: pc_write_en=1, ifid_write_en=1, ifid_flush=0.
  - If branch_taken: PCSrc=1, PCimm_out=branch_target in the same cycle (zero latency), ifid_flush=1. Counter loads FLUSH_CYCLES-1; next state FLUSH.
  - Else if stall_req: pc_write_en=0, ifid_write_en=0; next state STALL.
  - Branch has priority over stall when both are asserted.
- STALL:
  - While stall_req=1 and no branch: pc_write_en=0, ifid_write_en=0; stay in STALL.
  - stall_req=0: enables 1 in that same cycle; next state RUN.
  - branch_taken: handled exactly as in RUN (redirect, flush, go to FLUSH), regardless of stall_req.
- FLUSH:
  - pc_write_en=1, ifid_write_en=1, ifid_flush=1.
  - Counter decrements; at 0, next state is RUN.
  - branch_taken and stall_req are ignored, since they originate from squashed wrong-path instructions.
- fetch_valid update at each edge:
  - 0 if reset==0 or ifid_flush=1.
  - Else 1 if ifid_write_en=1.
  - Else hold.
- PCimm_out is a pass-through of branch_target, XLEN bits, no arithmetic.
- Counter width is clog2 of the maximum of the two count parameters, minimum 1 bit.

Optional Feature:
- Macro: FETCH_CTRL_PERF_CNT_EN.
- When defined, adds outputs stall_count (32) and flush_count (32):
  - stall_count increments every cycle pc_write_en=0 in RUN or STALL.
  - flush_count increments on each accepted redirect.
  - Both saturate at 0xFFFFFFFF and are cleared by reset.
- When undefined, the ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
1. reset=0 for 3 cycles, then 1; RESET_HOLD_CYCLES=2 -> ctrl_state=00 with pc_write_en=0 for 2 cycles after release, then ctrl_state=01 with pc_write_en=1; fetch_valid=1 one edge later.
2. RUN, branch_taken=1 with target 0x2C for one cycle -> same cycle PCSrc=1, PCimm_out=0x2C, ifid_flush=1; next cycle ctrl_state=11, fetch_valid=0; following cycle ctrl_state=01, then fetch_valid=1.
3. RUN, stall_req=1 for 3 cycles -> pc_write_en=ifid_write_en=0 for exactly those 3 cycles; ctrl_state=10 on cycles 2–3; enables return to 1 on cycle 4 with ctrl_state=01 afterwards.
4. branch_taken=1 with target 0x1E8 and stall_req=1 in the same RUN cycle -> PCSrc=1, pc_write_en=1, PCimm_out=0x1E8, next state FLUSH, STALL never entered.
5. In FLUSH, branch_taken=1 with target 0x10 -> PCSrc=0, PCimm_out=0, state returns to RUN after FLUSH_CYCLES; with the macro defined, flush_count increments only once.
6. reset=0 asserted mid-STALL -> next edge ctrl_state=00, all outputs at reset values, fetch_valid=0; with the macro defined, stall_count=0 and flush_count=0.
